// File: rtl/seg_scan_2digit.sv
// Two-digit seven-segment scanner: SHOW0/GUARD0/SHOW1/GUARD1 frame, snapshot taken at frame start, leading-zero blanking.
// Latency: inputs appear at the next frame edge (at most one frame later); no backpressure, the scan free-runs.
module seg_scan_2digit #(
    parameter int SCAN_DIV      = 8,
    parameter int GUARD         = 2,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int MAXLEN = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int CW     = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {SHOW0, GUARD0, SHOW1, GUARD1} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [3:0]    snap1, snap0, nxt_snap1, nxt_snap0;
    logic [1:0]    nxt_an;
    logic [6:0]    nxt_seg;
    logic          nxt_tick;
    logic          last;
    int            len;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        len       = ((state == SHOW0) || (state == SHOW1)) ? SCAN_DIV : GUARD;
        last      = (cnt == CW'(len - 1));
        nxt_state = state;
        nxt_cnt   = last ? '0 : cnt + CW'(1);
        nxt_snap1 = snap1;
        nxt_snap0 = snap0;
        if (last) begin
            case (state)
                SHOW0:   nxt_state = GUARD0;
                GUARD0:  nxt_state = SHOW1;
                SHOW1:   nxt_state = GUARD1;
                default: begin
                    nxt_state = SHOW0;
                    nxt_snap1 = dig1;
                    nxt_snap0 = dig0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values so they can be registered without adding a cycle.
    always_comb begin
        nxt_an   = 2'b11;
        nxt_seg  = 7'h7F;
        nxt_tick = (nxt_state == SHOW0) && (nxt_cnt == '0);
        case (nxt_state)
            SHOW0: begin
                nxt_an  = 2'b10;
                nxt_seg = decode(nxt_snap0);
            end
            SHOW1: begin
                if (!(BLANK_LEADING && (nxt_snap1 == 4'd0))) begin
                    nxt_an  = 2'b01;
                    nxt_seg = decode(nxt_snap1);
                end
            end
            default: begin
                nxt_an  = 2'b11;
                nxt_seg = 7'h7F;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= GUARD1;
            cnt        <= '0;
            snap1      <= 4'd0;
            snap0      <= 4'd0;
            an         <= 2'b11;
            seg        <= 7'h7F;
            frame_tick <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            snap1      <= nxt_snap1;
            snap0      <= nxt_snap0;
            an         <= nxt_an;
            seg        <= nxt_seg;
            frame_tick <= nxt_tick;
        end
    end

endmodule

// File: tb/tb_seg_scan_2digit.sv
// Bench for seg_scan_2digit: two instances (leading-zero blanking on/off) against a frame-position reference model.
module tb_seg_scan_2digit;

    localparam int S = 8;
    localparam int G = 2;
    localparam int F = 2 * (S + G);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dig1  = 4'd0;
    logic [3:0] dig0  = 4'd0;
    logic [1:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       ft_a, ft_b;

    int         tests = 0;
    int         fails = 0;
    int         k     = 0;
    logic [3:0] m1    = 4'd0;
    logic [3:0] m0    = 4'd0;
    int         val   = 0;

    always #5 clock = ~clock;

    seg_scan_2digit #(.SCAN_DIV(S), .GUARD(G), .BLANK_LEADING(1'b1)) dut_a (
        .clock(clock), .reset(reset), .dig1(dig1), .dig0(dig0),
        .an(an_a), .seg(seg_a), .frame_tick(ft_a)
    );

    seg_scan_2digit #(.SCAN_DIV(S), .GUARD(G), .BLANK_LEADING(1'b0)) dut_b (
        .clock(clock), .reset(reset), .dig1(dig1), .dig0(dig0),
        .an(an_b), .seg(seg_b), .frame_tick(ft_b)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d <= 4'd9) return tab[d];
        return 7'h3F;
    endfunction

    // Cycles since the current frame started; -1 while still in the post-reset guard.
    function automatic int pos();
        if (k < G) return -1;
        return (k - G) % F;
    endfunction

    task automatic check_one(input string tag, input logic [1:0] an, input logic [6:0] seg,
                             input logic ft, input bit bl);
        logic [1:0] e_an;
        logic [6:0] e_seg;
        logic       e_ft;
        int         p;
        p     = pos();
        e_an  = 2'b11;
        e_seg = 7'h7F;
        e_ft  = (p == 0);
        if (p >= 0 && p < S) begin
            e_an  = 2'b10;
            e_seg = seg_of(m0);
        end else if (p >= S + G && p < 2 * S + G) begin
            if (!(bl && m1 == 4'd0)) begin
                e_an  = 2'b01;
                e_seg = seg_of(m1);
            end
        end
        tests++;
        assert (an === e_an) else begin
            fails++;
            $error("FAIL %s.an k=%0d got %b want %b", tag, k, an, e_an);
        end
        tests++;
        assert (seg === e_seg) else begin
            fails++;
            $error("FAIL %s.seg k=%0d got %h want %h", tag, k, seg, e_seg);
        end
        tests++;
        assert (ft === e_ft) else begin
            fails++;
            $error("FAIL %s.frame_tick k=%0d got %b want %b", tag, k, ft, e_ft);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) begin
            k  = 0;
            m1 = 4'd0;
            m0 = 4'd0;
        end else begin
            k++;
            if (k >= G && (k - G) % F == 0) begin
                m1 = dig1;
                m0 = dig0;
            end
        end
        @(negedge clock);
        check_one("bl1", an_a, seg_a, ft_a, 1'b1);
        check_one("bl0", an_b, seg_b, ft_b, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_pos(input int target);
        int budget;
        budget = 4 * F;
        while (pos() != target && budget > 0) begin
            step();
            budget--;
        end
        tests++;
        assert (budget > 0) else begin
            fails++;
            $error("FAIL run_to_pos target=%0d got %0d want %0d", target, pos(), target);
        end
    endtask

    initial begin
        reset = 1'b0;
        dig1  = 4'd9;
        dig0  = 4'd9;
        run(5);
        reset = 1'b1;
        dig1  = 4'd4;
        dig0  = 4'd2;
        run(3 * F);

        dig1 = 4'd0;
        dig0 = 4'd7;
        run(2 * F);
        dig0 = 4'd0;
        run(2 * F);

        dig1 = 4'hA;
        dig0 = 4'hF;
        run(2 * F);

        dig1 = 4'd1;
        dig0 = 4'd3;
        run_to_pos(0);
        run_to_pos(4);
        dig0 = 4'd5;
        run(2 * F);

        // Live counter-like stimulus with occasional invalid codes.
        val = 0;
        for (int i = 0; i < 40 * F; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                val  = (val + 1) % 100;
                dig1 = 4'(val / 10);
                dig0 = 4'(val % 10);
            end
            if ($urandom_range(0, 63) == 0) dig1 = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 63) == 0) dig0 = 4'($urandom_range(10, 15));
            step();
        end

        dig1 = 4'd6;
        dig0 = 4'd8;
        run_to_pos(12);
        reset = 1'b0;
        step();
        reset = 1'b1;
        run(2 * F + 5);

        // Random short resets at arbitrary frame positions.
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(1, 2 * F));
            dig1  = 4'($urandom_range(0, 9));
            dig0  = 4'($urandom_range(0, 9));
            reset = 1'b0;
            run($urandom_range(1, 3));
            reset = 1'b1;
        end
        run(2 * F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
